nios2_oci_ram_access_sched: RTL

- Sequences and shares the single-port on-chip-instrumentation (OCI) debug RAM between two requesters.
  - The JTAG debug path: take_action_ocimem_* strobes with the jdo payload, in the clk domain.
  - The CPU-side debug slave port.
- Produces MonDReg, monitor_ready and monitor_error, which feed back into the JTAG debug module for host readback.
- Sits between the JTAG debug module sysclk logic, the CPU debug slave and the OCI RAM macro.

---
 rtl/nios2_oci_pkg.sv | 18 +
 rtl/nios2_oci_rr_arb.sv | 43 ++++
 rtl/nios2_oci_ram_access_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/nios2_oci_pkg.sv
// nios2_oci_pkg: shared types and jdo field positions for the OCI RAM
// access scheduler.
package nios2_oci_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_C   = 3'd1,
        RD_J   = 3'd2,
        DONE_C = 3'd3,
        DONE_J = 3'd4
    } sched_state_t;

    localparam int JDO_GO        = 35;
    localparam int JDO_RNW       = 34;
    localparam int JDO_ADDR_LSB  = 26;
    localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios2_oci_rr_arb.sv
// nios2_oci_rr_arb: two-requester grant for the OCI RAM (CPU vs JTAG).
// Build option: OCI_SCHED_JTAG_PRIO_EN selects fixed JTAG priority and
// removes the last-winner flag; otherwise grants alternate on contention.
module nios2_oci_rr_arb (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic req_c,
    input  logic req_j,
    output logic gnt_c,
    output logic gnt_j
);

`ifdef OCI_SCHED_JTAG_PRIO_EN

    assign gnt_j = en && req_j;
    assign gnt_c = en && req_c && !req_j;

    logic unused_arb;
    assign unused_arb = &{1'b0, clk, reset_n};

`else

    // 1: the CPU won the most recent grant; resets to CPU so JTAG wins first
    logic last_c;

    // remember the most recent winner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_c <= 1'b1;
        end else if (gnt_c) begin
            last_c <= 1'b1;
        end else if (gnt_j) begin
            last_c <= 1'b0;
        end
    end

    assign gnt_j = en && req_j && (!req_c || last_c);
    assign gnt_c = en && req_c && (!req_j || !last_c);

`endif

endmodule

// File: rtl/nios2_oci_ram_access_sched.sv
// nios2_oci_ram_access_sched: shares the single-port OCI debug RAM between
// the JTAG debug path (one-deep pending slot) and the CPU debug slave.
// Build option: OCI_SCHED_JTAG_PRIO_EN gives JTAG fixed priority in IDLE.
//
// state  | meaning
// IDLE   | arbitrate; the winner gets ram_en in this same cycle
// RD_C   | RAM read data for the CPU is valid; capture into cpu_rdata
// RD_J   | RAM read data for JTAG is valid; capture into MonDReg
// DONE_C | pulse cpu_ack
// DONE_J | set monitor_ready, free the slot, bump MonAReg after a write
module nios2_oci_ram_access_sched
    import nios2_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int JDO_W  = 38
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    sched_state_t      state_q, state_d;
    logic [ADDR_W-1:0] mon_a_reg;
    logic              pend_vld;
    logic              pend_we;
    logic [DATA_W-1:0] pend_wdata;
    logic              gnt_c, gnt_j;

    logic jtag_addr_cmd, jtag_rd_cmd, jtag_wr_cmd;
    logic slot_free, queue_cmd, accept, drop;

    // The slot being released in DONE_J can be refilled in that same cycle.
    assign slot_free     = !pend_vld || (state_q == DONE_J);
    assign jtag_addr_cmd = take_action_ocimem_a && jdo[JDO_GO] && jdo[JDO_RNW];
    assign jtag_rd_cmd   = take_action_ocimem_a && jdo[JDO_GO] && !jdo[JDO_RNW];
    assign jtag_wr_cmd   = take_action_ocimem_b;
    assign queue_cmd     = jtag_rd_cmd || jtag_wr_cmd;
    assign accept        = queue_cmd && slot_free;
    assign drop          = queue_cmd && !slot_free;

    logic unused_jdo;
    assign unused_jdo = &{1'b0, jdo[JDO_W-1:JDO_GO+1], jdo[JDO_WDATA_LSB-1:0]};

    nios2_oci_rr_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_q == IDLE),
        .req_c   (cpu_req),
        .req_j   (pend_vld),
        .gnt_c   (gnt_c),
        .gnt_j   (gnt_j)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and RAM port drive; the grant issues ram_en in IDLE
    always_comb begin
        state_d   = state_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            IDLE: begin
                if (gnt_c) begin
                    ram_en    = 1'b1;
                    ram_we    = cpu_we;
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_we ? cpu_wdata : '0;
                    state_d   = cpu_we ? DONE_C : RD_C;
                end else if (gnt_j) begin
                    ram_en    = 1'b1;
                    ram_we    = pend_we;
                    ram_addr  = mon_a_reg;
                    ram_wdata = pend_we ? pend_wdata : '0;
                    state_d   = pend_we ? DONE_J : RD_J;
                end
            end
            RD_C:    state_d = DONE_C;
            RD_J:    state_d = DONE_J;
            DONE_C:  state_d = IDLE;
            DONE_J:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cpu_ack = (state_q == DONE_C);

    // JTAG pending slot; the command stays held until DONE_J releases it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld   <= 1'b0;
            pend_we    <= 1'b0;
            pend_wdata <= '0;
        end else if (accept) begin
            pend_vld   <= 1'b1;
            pend_we    <= jtag_wr_cmd;
            pend_wdata <= jdo[JDO_WDATA_LSB +: DATA_W];
        end else if (state_q == DONE_J) begin
            pend_vld   <= 1'b0;
        end
    end

    // MonAReg: a new address load beats the post-write increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_a_reg <= '0;
        end else if (jtag_addr_cmd || (jtag_rd_cmd && slot_free)) begin
            mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
        end else if ((state_q == DONE_J) && pend_we) begin
            mon_a_reg <= mon_a_reg + ADDR_W'(1);
        end
    end

    // read data capture, one cycle after the read grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata <= '0;
            MonDReg   <= '0;
        end else begin
            if (state_q == RD_C) cpu_rdata <= ram_rdata;
            if (state_q == RD_J) MonDReg   <= ram_rdata;
        end
    end

    // monitor flags: a newly accepted command clears ready; set beats clear on error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (accept) begin
                monitor_ready <= 1'b0;
            end else if (state_q == DONE_J) begin
                monitor_ready <= 1'b1;
            end
            if (drop) begin
                monitor_error <= 1'b1;
            end else if (take_no_action_ocimem_a) begin
                monitor_error <= 1'b0;
            end
        end
    end

endmodule
